// File: rtl/divider_sequencer.sv
// Divider sequencer: re-arms the downstream divide counter, waits for its (asynchronous)
// completion flag and emits a divided output pulse of programmable width.
module divider_sequencer #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned WIDTH_BITS   = 16
) (
  input  logic                  seq_clk,
  input  logic                  seq_reset,
  input  logic                  seq_arm,
  input  logic                  seq_abort,
  input  logic                  seq_mode,
  input  logic [WIDTH_BITS-1:0] pulse_width,
  input  logic                  count_completed_in,
  output logic                  count_enable_out,
  output logic                  count_reset_out,
  output logic                  div_pulse_out,
  output logic                  seq_busy,
  output logic [31:0]           pulse_total
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StRun   = 3'd2,
    StPulse = 3'd3,
    StRearm = 3'd4,
    StAbort = 3'd5
  } state_e;

  localparam logic [7:0] HoldLoad = 8'(RESET_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic [7:0]            hold_q, hold_d;
  logic [WIDTH_BITS-1:0] pcnt_q, pcnt_d;
  logic [WIDTH_BITS-1:0] width_q, width_d;
  logic                  mode_q, mode_d;
  logic [31:0]           total_q, total_d;
  logic                  en_q, rst_q, pulse_q, busy_q;
  logic [WIDTH_BITS-1:0] pcnt_load;

  // A latched width of zero behaves as a one-cycle pulse.
  assign pcnt_load = (width_q == '0) ? '0 : width_q - WIDTH_BITS'(1);

  // Next-state decode: abort beats internal transitions, which beat arm.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pcnt_d  = pcnt_q;
    width_d = width_q;
    mode_d  = mode_q;
    total_d = total_q;
    unique case (state_q)
      StIdle: begin
        if (seq_arm) begin
          state_d = StClear;
          hold_d  = HoldLoad;
          mode_d  = seq_mode;
          width_d = pulse_width;
        end
      end
      StClear, StRearm, StAbort: begin
        if (seq_abort) begin
          state_d = StAbort;
          hold_d  = HoldLoad;
        end else if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end else if (!sync2_q) begin
          // Leave only once the counter has dropped its completion flag.
          if (state_q == StClear) begin
            state_d = StRun;
          end else if (state_q == StRearm) begin
            state_d = mode_q ? StRun : StIdle;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StRun: begin
        if (seq_abort) begin
          state_d = StAbort;
          hold_d  = HoldLoad;
        end else if (sync2_q) begin
          state_d = StPulse;
          pcnt_d  = pcnt_load;
          total_d = (total_q == 32'hFFFF_FFFF) ? total_q : total_q + 32'd1;
        end
      end
      StPulse: begin
        if (seq_abort) begin
          state_d = StAbort;
          hold_d  = HoldLoad;
        end else if (pcnt_q == '0) begin
          state_d = StRearm;
          hold_d  = HoldLoad;
        end else begin
          pcnt_d = pcnt_q - WIDTH_BITS'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, synchronizer and outputs; outputs decode the next state so they move with it.
  always_ff @(posedge seq_clk) begin
    if (seq_reset) begin
      state_q <= StIdle;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hold_q  <= '0;
      pcnt_q  <= '0;
      width_q <= '0;
      mode_q  <= 1'b0;
      total_q <= '0;
      en_q    <= 1'b0;
      rst_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= count_completed_in;
      sync2_q <= sync1_q;
      hold_q  <= hold_d;
      pcnt_q  <= pcnt_d;
      width_q <= width_d;
      mode_q  <= mode_d;
      total_q <= total_d;
      en_q    <= (state_d == StRun);
      rst_q   <= (state_d == StClear) || (state_d == StRearm) || (state_d == StAbort);
      pulse_q <= (state_d == StPulse);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign count_enable_out = en_q;
  assign count_reset_out  = rst_q;
  assign div_pulse_out    = pulse_q;
  assign seq_busy         = busy_q;
  assign pulse_total      = total_q;

endmodule

// File: doc/divider_sequencer.md
Name: divider_sequencer

Overview:
- Control stage directly downstream of the 32-bit divide counter.
- Consumes the counter's completion flag, which arrives asynchronously from the count domain, and produces a divided output pulse of programmable width.
- Drives the counter's enable and reset lines to re-arm it, in either single-shot or continuous mode.
- Runs entirely in the system clock domain.

Parameters:
- RESET_CYCLES, 4: cycles count_reset_out is held high per clear; legal range 1..255.
- WIDTH_BITS, 16: width of pulse_width.

Ports:
- seq_clk, in, 1: system clock; all logic on its rising edge.
- seq_reset, in, 1: synchronous, active-high reset.
- seq_arm, in, 1: start request; sampled only in IDLE.
- seq_abort, in, 1: stop request; honoured in any non-IDLE state.
- seq_mode, in, 1: 0 = single-shot, 1 = continuous; latched on accepted arm.
- pulse_width, in, WIDTH_BITS: output pulse length in seq_clk cycles; latched on accepted arm.
- count_completed_in, in, 1: counter completion flag, asynchronous to seq_clk.
- count_enable_out, out, 1: counter enable.
- count_reset_out, out, 1: counter reset, active-high.
- div_pulse_out, out, 1: divided output pulse.
- seq_busy, out, 1: high whenever state is not IDLE.
- pulse_total, out, 32: number of pulses emitted since seq_reset; saturating.

Behaviour:
- Reset values: state IDLE; every output 0; sync flops 0; latched mode/width 0; pulse_total 0.
- Synchronizer: count_completed_in passes through two flops (sync1 -> sync2). The FSM uses only sync2.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- IDLE: enable=0, reset=0, pulse=0.
  - seq_arm=1 -> CLEAR; latch seq_mode and pulse_width.
  - A latched width of 0 is treated as 1.
- CLEAR: count_reset_out=1, enable=0.
  - Hold counter loads RESET_CYCLES-1 on entry.
  - Exit when hold counter reaches 0 and sync2=0 -> RUN.
  - If sync2 stays high, remain in CLEAR with reset asserted; no timeout.
- RUN: count_enable_out=1, count_reset_out=0.
  - sync2=1 -> PULSE.
  - Latency: count_completed_in sampled high by sync1 at edge k gives div_pulse_out high after edge k+2.
- PULSE: div_pulse_out=1, enable=0.
  - Held for exactly max(latched width, 1) cycles.
  - pulse_total increments once on entry; it stays at 0xFFFFFFFF once there, with no wrap.
  - On width expiry -> REARM.
- REARM: identical to CLEAR (reset hold plus sync2=0 gate).
  - On exit -> RUN if latched mode=1, else IDLE.
- Abort:
  - seq_abort=1 in RUN, PULSE or REARM -> ABORT on the next edge. div_pulse_out drops immediately, truncating the pulse; pulse_total is not decremented.
  - seq_abort=1 in CLEAR -> ABORT; the hold counter restarts.
- ABORT: behaves as CLEAR, then -> IDLE.
- Priority and simultaneous events:
  - seq_reset > seq_abort > internal transitions > seq_arm.
  - seq_arm outside IDLE is ignored.
  - seq_abort in IDLE is ignored.
  - seq_arm and seq_abort together in IDLE: arm is accepted, since abort is ignored in IDLE.
- seq_reset mid-operation: next edge forces IDLE and all outputs to 0, including an in-flight pulse. pulse_total clears to 0.
- pulse_width and seq_mode changes after an accepted arm have no effect until the next arm.
- seq_busy = (state != IDLE).

Test Plan:
- Basic single-shot:
  - Stimulus: reset; arm with mode=0, width=3; count_completed_in raised 10 cycles after entering RUN.
  - Required: count_reset_out high 4 cycles, then enable high; div_pulse_out high 3 cycles, starting 3 edges after completion is raised; then reset high 4 cycles and return to IDLE; pulse_total=1; busy low.
- Continuous:
  - Stimulus: mode=1, width=1; completion raised 3 times, each dropped when count_reset_out asserts.
  - Required: three 1-cycle pulses; the FSM returns to RUN each time; pulse_total=3.
- Width 0 and stuck completion:
  - Stimulus: arm with width=0 while count_completed_in is held high.
  - Required: FSM stays in CLEAR with reset asserted. After completion drops, RUN is entered; a later completion produces exactly a 1-cycle pulse.
- Abort mid-pulse:
  - Stimulus: width=10; abort asserted on the 4th pulse cycle.
  - Required: pulse is 4 cycles long; count_reset_out held 4 cycles; then IDLE; pulse_total=1.
- Reset mid-RUN:
  - Stimulus: seq_reset asserted for 1 cycle while enable=1.
  - Required: all outputs 0 after that edge; pulse_total=0; arm in the same cycle as reset is ignored.
- Saturation:
  - Stimulus: force pulse_total to 0xFFFFFFFE; complete 2 pulses.
  - Required: pulse_total reads 0xFFFFFFFF and remains there.
